fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Circular instruction buffer between the fetch stage and the decoder.
- Each entry holds {instr, pc, guesses_branch, prediction} from fetch and is presented in order on the decoder inputs (valid, i_instr, i_pc, guesses_branch, prediction).
- When the decoder reports a front-end redirect (o_branch_inconsistency, o_new_pc) or the backend flushes, the queue discards all wrong-path entries and steers fetch to the new PC.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- AW, `ADDR_WIDTH, PC and prediction width, from riscv_core.svh.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_enq_valid  in  1  fetch presents an instruction
- i_enq_instr  in  32  instruction word
- i_enq_pc  in  AW  instruction PC
- i_enq_guesses_branch  in  1  fetch predicted a taken control transfer
- i_enq_prediction  in  AW  predicted next PC
- o_enq_ready  out  1  queue can accept (not full)
- o_deq_valid  out  1  head entry valid; drives decoder valid
- o_deq_instr  out  32  head instruction
- o_deq_pc  out  AW  head PC
- o_deq_guesses_branch  out  1  head prediction flag
- o_deq_prediction  out  AW  head predicted PC
- i_deq_ready  in  1  downstream consumes head this cycle
- i_dec_redirect  in  1  decoder o_branch_inconsistency for the head
- i_dec_new_pc  in  AW  decoder o_new_pc
- i_flush  in  1  backend flush (mispredict or exception)
- i_flush_pc  in  AW  backend restart PC
- o_redirect  out  1  fetch must restart
- o_redirect_pc  out  AW  fetch restart PC
- o_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
Reset:
- head, tail and count are 0.
- o_deq_valid, o_redirect and o_count are 0.
- All o_deq_* data outputs are 0.
- o_enq_ready is 1.

Handshakes:
- Enqueue fires when i_enq_valid && o_enq_ready.
- Dequeue fires when o_deq_valid && i_deq_ready.
- o_enq_ready = (count != DEPTH). There is no same-cycle dequeue credit: a full queue accepts nothing that cycle, even if a dequeue fires.

Timing:
- o_deq_valid = (count != 0).
- o_deq_* come from storage at head, with no bypass. An entry enqueued into an empty queue appears on o_deq_* the next cycle (1-cycle latency).
- When empty, all o_deq_* data outputs are 0.

Decoder redirect (dec_redir):
- dec_redir = i_dec_redirect && o_deq_valid && i_deq_ready && !i_flush.
- On dec_redir, the head is consumed (it goes to decode), every other entry is cleared (head = tail = 0, count = 0), and any same-cycle enqueue is discarded.
- o_redirect and o_redirect_pc are combinational: o_redirect = 1 and o_redirect_pc = i_dec_new_pc in the same cycle. Fetch presents the corrected stream from the next cycle.
- i_dec_redirect is ignored when the queue is empty or i_deq_ready = 0.

Backend flush:
- i_flush has highest priority.
- On i_flush: all entries are dropped, pointers and count go to 0, and the same-cycle enqueue and dequeue are suppressed.
- o_redirect = 1 and o_redirect_pc = i_flush_pc, combinationally.
- If i_flush and dec_redir conditions occur together, o_redirect_pc = i_flush_pc.

Pointers:
- log2(DEPTH) bits; they wrap from DEPTH-1 to 0 naturally.
- count is updated as +1 (enqueue only), −1 (dequeue only), or unchanged (both or neither).

Reset mid-operation:
- Asserting n_rst low at any time returns all state to the reset values immediately.
- Entry storage need not be cleared; outputs are masked by count.

Other outputs:
- o_redirect is 0 in every cycle not listed above.
- Illegal dequeue on empty or enqueue on full is ignored; the bench also asserts it never happens.

Decomposition:
- Add to riscv_core.svh / core package:
  - typedef struct packed fq_entry_t {instr[31:0], pc[AW-1:0], guesses_branch, prediction[AW-1:0]}
  - FQ_DEPTH constant
- Storage is an array of fq_entry_t inside fetch_queue.
- No sub-module: pointer/count logic and flush priority sit in one always_ff plus one always_comb.

Test Plan:
1. Reset, then enqueue 3 instrs (pc 0x0, 0x4, 0x8) with i_deq_ready = 0. Required: o_count = 3, o_deq_pc = 0x0. Then i_deq_ready = 1 for 3 cycles: o_deq_pc sequence 0x0, 0x4, 0x8, then o_deq_valid = 0.
2. Fill DEPTH = 8 entries. Required: o_enq_ready = 0. Then assert enqueue and dequeue in the same cycle: count stays 7 after the dequeue (enqueue rejected), and the 9th instr is accepted the next cycle. Pointers wrap correctly over 20 more transactions (PC order preserved).
3. Queue holds pc 0x10, 0x14 (jal +0x40 at 0x10 unpredicted), 0x18. Assert i_dec_redirect with i_dec_new_pc = 0x50 while dequeuing 0x10, plus a same-cycle enqueue of 0x1C. Required: o_redirect = 1 and o_redirect_pc = 0x50 that cycle, o_count = 0 next cycle, 0x1C never appears.
4. i_flush with i_flush_pc = 0x200 in the same cycle as dec_redir (new_pc 0x50), enqueue and dequeue. Required: o_redirect_pc = 0x200, count = 0 next cycle, head not consumed.
5. Assert i_dec_redirect while empty, or while i_deq_ready = 0. Required: o_redirect stays 0 and contents are unchanged.
6. Drop n_rst asynchronously mid-stream with 5 entries. Required: o_deq_valid = 0, o_count = 0 and o_enq_ready = 1 without waiting for a clock edge; normal operation after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue that sits between the
// fetch stage and the decoder.
package fetch_queue_pkg;

  // Width of PCs and predicted next-PCs carried through the queue.
  localparam int ADDR_WIDTH = 32;

  // Default number of queue entries (power of two, at least 2).
  localparam int FQ_DEPTH = 8;

  // One buffered fetch packet, kept exactly as fetch produced it.
  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  guesses_branch;
    logic [ADDR_WIDTH-1:0] prediction;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the enqueue, dequeue and redirect signals of the fetch queue.
// The slave modport is the queue itself; the master modport is the
// surrounding front end (fetch, decoder and backend flush logic).
interface fetch_queue_if #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH
);

  localparam int AW = fetch_queue_pkg::ADDR_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  // Fetch side
  logic          i_enq_valid;
  logic [31:0]   i_enq_instr;
  logic [AW-1:0] i_enq_pc;
  logic          i_enq_guesses_branch;
  logic [AW-1:0] i_enq_prediction;
  logic          o_enq_ready;

  // Decoder side
  logic          o_deq_valid;
  logic [31:0]   o_deq_instr;
  logic [AW-1:0] o_deq_pc;
  logic          o_deq_guesses_branch;
  logic [AW-1:0] o_deq_prediction;
  logic          i_deq_ready;

  // Redirect sources and the resulting fetch restart
  logic          i_dec_redirect;
  logic [AW-1:0] i_dec_new_pc;
  logic          i_flush;
  logic [AW-1:0] i_flush_pc;
  logic          o_redirect;
  logic [AW-1:0] o_redirect_pc;

  // Occupancy
  logic [CW-1:0] o_count;

  modport slave (
    input  i_enq_valid, i_enq_instr, i_enq_pc, i_enq_guesses_branch, i_enq_prediction,
    output o_enq_ready,
    output o_deq_valid, o_deq_instr, o_deq_pc, o_deq_guesses_branch, o_deq_prediction,
    input  i_deq_ready,
    input  i_dec_redirect, i_dec_new_pc, i_flush, i_flush_pc,
    output o_redirect, o_redirect_pc,
    output o_count
  );

  modport master (
    output i_enq_valid, i_enq_instr, i_enq_pc, i_enq_guesses_branch, i_enq_prediction,
    input  o_enq_ready,
    input  o_deq_valid, o_deq_instr, o_deq_pc, o_deq_guesses_branch, o_deq_prediction,
    output i_deq_ready,
    output i_dec_redirect, i_dec_new_pc, i_flush, i_flush_pc,
    input  o_redirect, o_redirect_pc,
    input  o_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode. Entries leave in
// order from the head; a decoder redirect consumes the head and discards
// the rest, and a backend flush discards everything. Either event steers
// fetch to a new PC in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input logic            clk,
  input logic            n_rst,
  fetch_queue_if.slave   bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage is not reset; the outputs are masked by the occupancy count.
  fq_entry_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic      notEmpty;
  logic      notFull;
  logic      enqFire;
  logic      deqFire;
  logic      decRedir;
  logic      writeEn;
  fq_entry_t enqEntry;
  fq_entry_t headEntry;

  // Handshake qualification; a flush outranks a decoder redirect.
  always_comb begin
    notEmpty = (count_q != '0);
    notFull  = (count_q != CW'(DEPTH));
    enqFire  = bus.i_enq_valid && notFull;
    deqFire  = notEmpty && bus.i_deq_ready;
    decRedir = bus.i_dec_redirect && deqFire && !bus.i_flush;
    writeEn  = enqFire && !bus.i_flush && !decRedir;
  end

  // Pack the incoming fetch packet into a storage entry.
  always_comb begin
    enqEntry.instr          = bus.i_enq_instr;
    enqEntry.pc             = bus.i_enq_pc;
    enqEntry.guesses_branch = bus.i_enq_guesses_branch;
    enqEntry.prediction     = bus.i_enq_prediction;
  end

  // Next pointer/count: any redirect empties the queue, otherwise advance
  // each pointer on its own handshake and adjust the count by the net change.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.i_flush || decRedir) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enqFire) begin
        tail_d = tail_q + PW'(1);
      end
      if (deqFire) begin
        head_d = head_q + PW'(1);
      end
      if (enqFire && !deqFire) begin
        count_d = count_q + CW'(1);
      end else if (!enqFire && deqFire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer and count registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: write the accepted packet at the tail.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem_q[tail_q] <= enqEntry;
    end
  end

  // Present the head entry to the decoder, forced to zero while empty.
  always_comb begin
    headEntry = mem_q[head_q];
    bus.o_enq_ready = notFull;
    bus.o_deq_valid = notEmpty;
    bus.o_count     = count_q;
    if (notEmpty) begin
      bus.o_deq_instr          = headEntry.instr;
      bus.o_deq_pc             = headEntry.pc;
      bus.o_deq_guesses_branch = headEntry.guesses_branch;
      bus.o_deq_prediction     = headEntry.prediction;
    end else begin
      bus.o_deq_instr          = '0;
      bus.o_deq_pc             = '0;
      bus.o_deq_guesses_branch = 1'b0;
      bus.o_deq_prediction     = '0;
    end
  end

  // Fetch restart: the backend PC wins over the decoder PC.
  always_comb begin
    bus.o_redirect    = bus.i_flush || decRedir;
    bus.o_redirect_pc = '0;
    if (bus.i_flush) begin
      bus.o_redirect_pc = bus.i_flush_pc;
    end else if (decRedir) begin
      bus.o_redirect_pc = bus.i_dec_new_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order scoreboard of enqueued PCs.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic n_rst;

  fetch_queue_if #(.DEPTH(DEPTH)) fqIf ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (fqIf.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of PCs in the order the queue must deliver them.
  logic [31:0] expQ [$];

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'h1300_0093;
  endfunction

  function automatic logic [31:0] predOf(input logic [31:0] pc);
    return pc + 32'h40;
  endfunction

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, check the DUT against
  // the scoreboard, then advance the scoreboard the way the queue must.
  task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic dr,
                               input logic rd, input logic [31:0] npc,
                               input logic fl, input logic [31:0] fpc);
    logic accept, take, dRedir;
    @(negedge clk);
    fqIf.i_enq_valid          = ev;
    fqIf.i_enq_pc             = pc;
    fqIf.i_enq_instr          = instrOf(pc);
    fqIf.i_enq_guesses_branch = pc[2];
    fqIf.i_enq_prediction     = predOf(pc);
    fqIf.i_deq_ready          = dr;
    fqIf.i_dec_redirect       = rd;
    fqIf.i_dec_new_pc         = npc;
    fqIf.i_flush              = fl;
    fqIf.i_flush_pc           = fpc;
    #1;
    accept = ev && (expQ.size() != DEPTH);
    take   = dr && (expQ.size() != 0);
    dRedir = rd && take && !fl;
    checkOutput("enq_ready", {31'd0, fqIf.o_enq_ready}, {31'd0, expQ.size() != DEPTH});
    checkOutput("deq_valid", {31'd0, fqIf.o_deq_valid}, {31'd0, expQ.size() != 0});
    checkOutput("count", 32'(fqIf.o_count), 32'(expQ.size()));
    if (expQ.size() != 0) begin
      checkOutput("deq_pc", fqIf.o_deq_pc, expQ[0]);
      checkOutput("deq_instr", fqIf.o_deq_instr, instrOf(expQ[0]));
      checkOutput("deq_pred", fqIf.o_deq_prediction, predOf(expQ[0]));
      checkOutput("deq_gb", {31'd0, fqIf.o_deq_guesses_branch}, {31'd0, expQ[0][2]});
    end else begin
      checkOutput("deq_pc_empty", fqIf.o_deq_pc, 32'd0);
      checkOutput("deq_instr_empty", fqIf.o_deq_instr, 32'd0);
    end
    checkOutput("redirect", {31'd0, fqIf.o_redirect}, {31'd0, fl || dRedir});
    if (fl) begin
      checkOutput("redirect_pc_flush", fqIf.o_redirect_pc, fpc);
    end else if (dRedir) begin
      checkOutput("redirect_pc_dec", fqIf.o_redirect_pc, npc);
    end
    if (fl || dRedir) begin
      expQ.delete();
    end else begin
      if (take) void'(expQ.pop_front());
      if (accept) expQ.push_back(pc);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic enq(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic deq();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] nextPc;
    n_rst = 1'b0;
    fqIf.i_enq_valid = 1'b0; fqIf.i_enq_pc = '0; fqIf.i_enq_instr = '0;
    fqIf.i_enq_guesses_branch = 1'b0; fqIf.i_enq_prediction = '0;
    fqIf.i_deq_ready = 1'b0; fqIf.i_dec_redirect = 1'b0; fqIf.i_dec_new_pc = '0;
    fqIf.i_flush = 1'b0; fqIf.i_flush_pc = '0;

    // Reset state while reset is held
    #2;
    checkOutput("rst_deq_valid", {31'd0, fqIf.o_deq_valid}, 32'd0);
    checkOutput("rst_count", 32'(fqIf.o_count), 32'd0);
    checkOutput("rst_enq_ready", {31'd0, fqIf.o_enq_ready}, 32'd1);
    checkOutput("rst_redirect", {31'd0, fqIf.o_redirect}, 32'd0);
    checkOutput("rst_deq_pc", fqIf.o_deq_pc, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // 1: three enqueues held, then drained in order
    $display("[TB] step 1: basic order");
    enq(32'h0); enq(32'h4); enq(32'h8);
    idle();
    deq(); deq(); deq();
    idle();

    // 2: fill, rejected enqueue on full with dequeue, then wrap traffic
    $display("[TB] step 2: full and wrap");
    for (int i = 0; i < DEPTH; i++) enq(32'h100 + 32'(i) * 4);
    idle();
    nextPc = 32'h100 + 32'(DEPTH) * 4;
    applyStimulus(1'b1, nextPc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    enq(nextPc);
    nextPc = nextPc + 4;
    for (int i = 0; i < 20; i++) begin
      logic ev, dr, acc;
      ev  = (i % 4) != 0;
      dr  = (i % 3) != 0;
      acc = ev && (expQ.size() != DEPTH);
      applyStimulus(ev, nextPc, dr, 1'b0, 32'h0, 1'b0, 32'h0);
      if (acc) nextPc = nextPc + 4;
    end
    while (expQ.size() != 0) deq();
    idle();

    // 3: decoder redirect consumes head, drops rest and same-cycle enqueue
    $display("[TB] step 3: decoder redirect");
    enq(32'h10); enq(32'h14); enq(32'h18);
    applyStimulus(1'b1, 32'h1C, 1'b1, 1'b1, 32'h50, 1'b0, 32'h0);
    idle();
    idle();

    // 4: flush together with decoder redirect, enqueue and dequeue
    $display("[TB] step 4: flush priority");
    enq(32'h20); enq(32'h24);
    applyStimulus(1'b1, 32'h28, 1'b1, 1'b1, 32'h50, 1'b1, 32'h200);
    idle();

    // 5: decoder redirect ignored when empty or not dequeuing
    $display("[TB] step 5: ignored redirect");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 1'b0, 32'h0);
    enq(32'h30); enq(32'h34);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h50, 1'b0, 32'h0);
    idle();
    deq(); deq();
    idle();

    // 6: asynchronous reset with five entries, then normal traffic
    $display("[TB] step 6: async reset");
    for (int i = 0; i < 5; i++) enq(32'h400 + 32'(i) * 4);
    idle();
    @(negedge clk);
    fqIf.i_enq_valid = 1'b0; fqIf.i_deq_ready = 1'b0;
    fqIf.i_dec_redirect = 1'b0; fqIf.i_flush = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("arst_deq_valid", {31'd0, fqIf.o_deq_valid}, 32'd0);
    checkOutput("arst_count", 32'(fqIf.o_count), 32'd0);
    checkOutput("arst_enq_ready", {31'd0, fqIf.o_enq_ready}, 32'd1);
    expQ.delete();
    @(negedge clk);
    n_rst = 1'b1;
    enq(32'h500); enq(32'h504);
    deq(); deq();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
